stat_bcd_scheduler: RTL

//  Time-shares one iterative shift-add-3 binary-to-BCD engine between the three performance

---
 rtl/stat_bcd_if.sv | 27 ++
 rtl/stat_bcd_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/stat_bcd_if.sv
// Counter inputs, control and decimal display outputs of the shared BCD scheduler.
interface stat_bcd_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic              hold;
  logic [DATA_W-1:0] zong_counter_data;
  logic [DATA_W-1:0] tiao_jian_counter_data;
  logic [DATA_W-1:0] wu_tiao_jian_counter_data;
  logic [19:0]       zong_bcd;
  logic [15:0]       tiao_bcd;
  logic [15:0]       wu_tiao_bcd;
  logic [2:0]        sat;
  logic [2:0]        upd_pulse;
  logic [1:0]        cur_ch;
  logic              busy;

  modport master (
    output en, hold, zong_counter_data, tiao_jian_counter_data, wu_tiao_jian_counter_data,
    input  zong_bcd, tiao_bcd, wu_tiao_bcd, sat, upd_pulse, cur_ch, busy
  );

  modport slave (
    input  en, hold, zong_counter_data, tiao_jian_counter_data, wu_tiao_jian_counter_data,
    output zong_bcd, tiao_bcd, wu_tiao_bcd, sat, upd_pulse, cur_ch, busy
  );
endinterface

// File: rtl/stat_bcd_scheduler.sv
// One shift-add-3 binary-to-BCD engine time-shared round-robin across the three
// performance counters; holds the latest decimal digits of each for the display mux.

// Per-nibble double-dabble correction: add 3 when the digit would overflow on shift.
module stat_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module stat_bcd_scheduler #(
  parameter int DATA_W      = 32,
  parameter int REFRESH_GAP = 0
) (
  input  logic     clk_n,
  input  logic     rst,
  stat_bcd_if.slave bus
);
  localparam int NDIG  = 10;
  localparam int ACC_W = NDIG * 4;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_WRITE, S_GAP} state_t;

  typedef struct packed {
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] bin;
    logic              sat_pend;
  } eng_t;

  state_t            state, state_nx;
  eng_t              eng;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        gap_cnt;
  logic [1:0]        cur_ch;
  logic [19:0]       zong_r;
  logic [15:0]       tiao_r, wu_r;
  logic [2:0]        sat_r, upd_r;

  logic [DATA_W-1:0]          cap_val;
  logic [63:0]                cap_wide;
  logic                       cap_sat;
  logic [NDIG-1:0][3:0]       acc_nib, adj_nib;
  logic [19:0]                z_wr;
  logic [15:0]                n_wr;
  logic                       gap_done;

  // Snapshot source follows the channel that owns the engine.
  always_comb begin
    cap_val = bus.zong_counter_data;
    unique case (cur_ch)
      2'd1:    cap_val = bus.tiao_jian_counter_data;
      2'd2:    cap_val = bus.wu_tiao_jian_counter_data;
      default: cap_val = bus.zong_counter_data;
    endcase
  end

  assign cap_wide = 64'(cap_val);
  assign cap_sat  = (cur_ch == 2'd0) ? (cap_wide > 64'd99999) : (cap_wide > 64'd9999);

  assign acc_nib = eng.acc;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    stat_bcd_add3 u_add3 (.d(acc_nib[i]), .q(adj_nib[i]));
  end

  assign z_wr = eng.sat_pend ? 20'h99999 : eng.acc[19:0];
  assign n_wr = eng.sat_pend ? 16'h9999  : eng.acc[15:0];

  // With no refresh gap the WRITE cycle doubles as the en sampling point.
  assign gap_done = (REFRESH_GAP == 0) ? (state == S_WRITE) : (state == S_GAP && gap_cnt == 8'd0);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (bus.en) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_SHIFT;
      S_SHIFT:   if (bit_cnt == '0) state_nx = S_WRITE;
      S_WRITE:   state_nx = gap_done ? (bus.en ? S_CAPTURE : S_IDLE) : S_GAP;
      S_GAP:     if (gap_done) state_nx = bus.en ? S_CAPTURE : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_n or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Engine: capture, then DATA_W shift-add-3 steps; runs full length even when saturated.
  always_ff @(posedge clk_n or posedge rst) begin
    if (rst) begin
      eng     <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cur_ch  <= 2'd0;
    end else begin
      unique case (state)
        S_CAPTURE: begin
          eng.acc      <= '0;
          eng.bin      <= cap_val;
          eng.sat_pend <= cap_sat;
          bit_cnt      <= CNT_W'(DATA_W - 1);
        end
        S_SHIFT: begin
          {eng.acc, eng.bin} <= {adj_nib, eng.bin} << 1;
          bit_cnt            <= bit_cnt - 1'b1;
        end
        S_WRITE: begin
          cur_ch  <= (cur_ch == 2'd2) ? 2'd0 : cur_ch + 2'd1;
          gap_cnt <= 8'(REFRESH_GAP - 1);
        end
        S_GAP: begin
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Display registers; hold on the WRITE edge suppresses the whole update.
  always_ff @(posedge clk_n or posedge rst) begin
    if (rst) begin
      zong_r <= '0;
      tiao_r <= '0;
      wu_r   <= '0;
      sat_r  <= '0;
      upd_r  <= '0;
    end else begin
      upd_r <= '0;
      if (state == S_WRITE && !bus.hold) begin
        sat_r[cur_ch] <= eng.sat_pend;
        upd_r[cur_ch] <= 1'b1;
        unique case (cur_ch)
          2'd1:    tiao_r <= n_wr;
          2'd2:    wu_r   <= n_wr;
          default: zong_r <= z_wr;
        endcase
      end
    end
  end

  assign bus.zong_bcd    = zong_r;
  assign bus.tiao_bcd    = tiao_r;
  assign bus.wu_tiao_bcd = wu_r;
  assign bus.sat         = sat_r;
  assign bus.upd_pulse   = upd_r;
  assign bus.cur_ch      = cur_ch;
  assign bus.busy        = (state != S_IDLE);
endmodule
